// File: rtl/core_seq_pkg.sv
// Shared types and defaults for the core run sequencer.
// No logic; CORE_SEQ_TIMEOUT_EN selects whether the RUN watchdog is built.
// Backpressure: n/a.
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DUMP,
        ST_FINISH
    } seq_state_t;

    typedef logic [7:0] byte_t;

    localparam logic [7:0]  DEF_LOAD_BASE = 8'd0;
    localparam int          DEF_LOAD_LEN  = 8;
    localparam logic [7:0]  DEF_DUMP_BASE = 8'd8;
    localparam int          DEF_DUMP_LEN  = 8;
    localparam logic [15:0] DEF_TIMEOUT   = 16'd4000;

`ifdef CORE_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

endpackage

// File: rtl/seq_timer.sv
// Saturating RUN-cycle counter with watchdog compare.
// Count updates one edge after enable; expire is combinational on the current count.
// Backpressure: none.
module seq_timer
    import core_seq_pkg::*;
#(
    parameter int            CW    = 16,
    parameter logic [CW-1:0] LIMIT = CW'(DEF_TIMEOUT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          expire
);

    localparam logic [CW-1:0] CNT_ONE = 1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_ONE;
        end
    end

    // High in the RUN cycle whose closing edge brings the count to LIMIT.
    assign expire = TIMEOUT_EN && enable && (count == LIMIT - CNT_ONE);

endmodule

// File: rtl/core_sequencer.sv
// Host run controller: load bytes into data memory, start the core, wait for done, dump results.
// Load write lands one cycle after accept; dump byte valid one cycle after entering DUMP, 1 byte/cycle.
// in_ready only in LOAD; out_data held while out_valid & !out_ready. RUN watchdog with CORE_SEQ_TIMEOUT_EN.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int            AW        = 8,
    parameter logic [AW-1:0] LOAD_BASE = AW'(DEF_LOAD_BASE),
    parameter int            LOAD_LEN  = DEF_LOAD_LEN,
    parameter logic [AW-1:0] DUMP_BASE = AW'(DEF_DUMP_BASE),
    parameter int            DUMP_LEN  = DEF_DUMP_LEN,
    parameter int            CW        = 16,
    parameter logic [CW-1:0] TIMEOUT   = CW'(DEF_TIMEOUT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wr_data,
    input  logic [7:0]    mem_rd_data,
    output logic          core_reset,
    output logic          core_start,
    input  logic          core_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycle_count
);

    localparam logic [AW:0]   LLEN     = (AW+1)'(LOAD_LEN);
    localparam logic [AW:0]   DLEN     = (AW+1)'(DUMP_LEN);
    localparam logic [AW:0]   IDX_ONE  = 1;
    localparam logic [AW-1:0] ADDR_ONE = 1;

    seq_state_t  state;
    logic [AW:0] idx;
    logic        timer_clear;
    logic        timer_en;
    logic        timer_expire;

    assign timer_clear = (state == ST_IDLE) && go;
    assign timer_en    = (state == ST_RUN);

    seq_timer #(
        .CW    (CW),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .count  (cycle_count),
        .expire (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            in_ready    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            core_reset  <= 1'b1;
            core_start  <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            finished    <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            mem_wr_en  <= 1'b0;
            core_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        finished  <= 1'b0;
                        timed_out <= 1'b0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        if (LLEN == '0) begin
                            state      <= ST_START;
                            core_reset <= 1'b0;
                            core_start <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // in_ready is registered high for the whole of LOAD.
                    if (in_valid) begin
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= LOAD_BASE + idx[AW-1:0];
                        mem_wr_data <= in_data;
                        idx         <= idx + IDX_ONE;
                        if (idx == LLEN - IDX_ONE) begin
                            state      <= ST_START;
                            in_ready   <= 1'b0;
                            core_reset <= 1'b0;
                            core_start <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (core_done) begin
                        idx <= '0;
                        if (DLEN == '0) begin
                            state      <= ST_FINISH;
                            finished   <= 1'b1;
                            core_reset <= 1'b1;
                        end else begin
                            state    <= ST_DUMP;
                            mem_addr <= DUMP_BASE;
                        end
                    end else if (timer_expire) begin
                        state      <= ST_FINISH;
                        timed_out  <= 1'b1;
                        finished   <= 1'b1;
                        core_reset <= 1'b1;
                    end
                end
                ST_DUMP: begin
                    // mem_addr runs one ahead so read data is ready when the slot frees.
                    if ((idx != DLEN) && (!out_valid || out_ready)) begin
                        out_data  <= mem_rd_data;
                        out_valid <= 1'b1;
                        idx       <= idx + IDX_ONE;
                        mem_addr  <= DUMP_BASE + idx[AW-1:0] + ADDR_ONE;
                    end else if (out_valid && out_ready) begin
                        out_valid  <= 1'b0;
                        state      <= ST_FINISH;
                        finished   <= 1'b1;
                        core_reset <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: expected writes/dump bytes queued at stimulus time,
// popped by negedge monitors; a second instance covers load-address wrap and skipped DUMP.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        go, in_valid, in_ready, mem_wr_en, core_reset, core_start, core_done;
    logic        out_valid, out_ready, busy, finished, timed_out;
    logic [7:0]  in_data, mem_addr, mem_wr_data, mem_rd_data, out_data, dump_seed;
    logic [15:0] cycle_count;

    logic        go_w, in_valid_w, in_ready_w, mem_wr_en_w, core_reset_w, core_start_w, core_done_w;
    logic        out_valid_w, busy_w, finished_w, timed_out_w;
    logic [7:0]  in_data_w, mem_addr_w, mem_wr_data_w, out_data_w;
    logic [15:0] cycle_count_w;

    assign mem_rd_data = (mem_addr >= 8'd8 && mem_addr < 8'd16) ? dump_seed + mem_addr : 8'h00;

    core_sequencer #(.TIMEOUT(16'd20)) dut (
        .clk(clk), .reset(reset), .go(go), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .core_reset(core_reset), .core_start(core_start),
        .core_done(core_done), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .finished(finished), .timed_out(timed_out), .cycle_count(cycle_count)
    );

    core_sequencer #(.LOAD_BASE(8'hFE), .LOAD_LEN(4), .DUMP_LEN(0)) dut_w (
        .clk(clk), .reset(reset), .go(go_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_data(in_data_w), .mem_wr_en(mem_wr_en_w), .mem_addr(mem_addr_w),
        .mem_wr_data(mem_wr_data_w), .mem_rd_data(8'h00), .core_reset(core_reset_w),
        .core_start(core_start_w), .core_done(core_done_w), .out_valid(out_valid_w),
        .out_ready(1'b1), .out_data(out_data_w), .busy(busy_w), .finished(finished_w),
        .timed_out(timed_out_w), .cycle_count(cycle_count_w)
    );

    int total = 0;
    int bad = 0;
    logic [15:0] wq[$];
    logic [15:0] wq2[$];
    logic [7:0]  dq[$];
    int dump_acc = 0;
    int ov_cnt = 0;
    int ov_w_cnt = 0;
    int start_cnt = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitors
    always @(negedge clk) begin
        logic [15:0] e;
        if (mem_wr_en === 1'b1) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wr_data);
            end else begin
                e = wq.pop_front();
                check("wr_addr", mem_addr, e[15:8]);
                check("wr_data", mem_wr_data, e[7:0]);
            end
        end
        if (mem_wr_en_w === 1'b1) begin
            if (wq2.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_w_unexpected: got addr 0x%0h, expected no write", mem_addr_w);
            end else begin
                e = wq2.pop_front();
                check("wr_w_addr", mem_addr_w, e[15:8]);
                check("wr_w_data", mem_wr_data_w, e[7:0]);
            end
        end
        if (out_valid_w === 1'b1) ov_w_cnt++;
    end

    // Dump monitor: pops on accept, checks hold during stall
    always @(negedge clk) begin
        if (prev_stall) begin
            check("dump_hold_valid", out_valid, 1);
            check("dump_hold_data", out_data, prev_data);
        end
        if (out_valid === 1'b1) ov_cnt++;
        if (out_valid === 1'b1 && out_ready) begin
            if (dq.size() == 0) begin
                total++; bad++;
                $display("FAIL dump_unexpected: got 0x%0h, expected no byte", out_data);
            end else begin
                check("dump_data", out_data, dq.pop_front());
            end
            dump_acc++;
        end
        prev_stall = (out_valid === 1'b1) && !out_ready;
        prev_data  = out_data;
    end

    // Start-pulse monitor
    always @(negedge clk) begin
        if (core_start === 1'b1) begin
            start_cnt++;
            check("start_core_reset_low", core_reset, 0);
        end
    end

    task automatic start_session();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        check("go_clears_finished", finished, 0);
        check("load_in_ready", in_ready, 1);
        check("load_busy", busy, 1);
    endtask

    task automatic load(input logic [7:0] base, input int gap);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            d = base + 8'(i);
            wq.push_back({8'(i), d});
            in_valid = 1'b1;
            in_data  = d;
            @(posedge clk); #1 in_valid = 1'b0;
            if (i < 7) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_start();
        for (int i = 0; i < 20 && core_start !== 1'b1; i++) @(negedge clk);
        check("start_seen", core_start, 1);
    endtask

    task automatic wait_finished(input int limit);
        for (int i = 0; i < limit && finished !== 1'b1; i++) @(negedge clk);
        check("finished_seen", finished, 1);
    endtask

    initial begin
        int base;
        logic [7:0] a;
        go = 0; in_valid = 0; in_data = 0; out_ready = 1; core_done = 0; dump_seed = 8'h98;
        go_w = 0; in_valid_w = 0; in_data_w = 0; core_done_w = 1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_core_reset", core_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_core_start", core_start, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_finished", finished, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_w_core_reset", core_reset_w, 1);
        reset = 1'b1;

        // Session 1: contiguous load, done in RUN cycle 5, free-flowing dump
        for (int i = 0; i < 8; i++) dq.push_back(8'hA0 + 8'(i));
        start_session();
        load(8'h10, 0);
        wait_start();
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 core_done = 1'b1;
        @(posedge clk); #1 core_done = 1'b0;
        check("s1_cycle_count", cycle_count, 5);
        wait_finished(100);
        check("s1_finish_busy", busy, 1);
        check("s1_finish_core_reset", core_reset, 1);
        check("s1_timed_out", timed_out, 0);
        @(posedge clk); #1;
        check("s1_idle_busy", busy, 0);
        check("s1_idle_finished", finished, 1);
        check("s1_idle_core_reset", core_reset, 1);
        check("s1_start_pulses", start_cnt, 1);
        check("s1_writes_left", wq.size(), 0);
        check("s1_dump_left", dq.size(), 0);

        // Session 2: sparse load, done during START (ignored) and RUN cycle 1, dump stall
        dump_seed = 8'hA8;
        for (int i = 0; i < 8; i++) dq.push_back(8'hB0 + 8'(i));
        start_session();
        load(8'h20, 1);
        wait_start();
        core_done = 1'b1;
        @(posedge clk); @(posedge clk); #1 core_done = 1'b0;
        check("s2_cycle_count", cycle_count, 1);
        base = dump_acc;
        for (int i = 0; i < 50 && dump_acc < base + 3; i++) @(negedge clk);
        check("s2_dump_progress", dump_acc >= base + 3, 1);
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_finished(100);
        check("s2_start_pulses", start_cnt, 2);
        check("s2_writes_left", wq.size(), 0);
        check("s2_dump_left", dq.size(), 0);
        check("s2_dump_total", dump_acc, 16);

        // Session 3: reset asserted in RUN
        start_session();
        load(8'h30, 0);
        wait_start();
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_core_reset", core_reset, 1);
        check("abort_cycle_count", cycle_count, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        reset = 1'b1;
        check("s3_start_pulses", start_cnt, 3);
        check("s3_writes_left", wq.size(), 0);

`ifdef CORE_SEQ_TIMEOUT_EN
        // Session 4: core never finishes, watchdog fires at 20 RUN cycles
        base = ov_cnt;
        start_session();
        load(8'h40, 0);
        wait_start();
        wait_finished(100);
        check("to_timed_out", timed_out, 1);
        check("to_cycle_count", cycle_count, 20);
        check("to_no_out_valid", ov_cnt, base);
        @(posedge clk); #1;
        check("to_idle_busy", busy, 0);
`endif

        // Wrap instance: LOAD_BASE=FE, 4 bytes, no DUMP, core_done held high throughout
        @(posedge clk); #1 go_w = 1'b1;
        @(posedge clk); #1 go_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 8'hFE + 8'(i);
            wq2.push_back({a, 8'hC0 + 8'(i)});
            in_valid_w = 1'b1;
            in_data_w  = 8'hC0 + 8'(i);
            @(posedge clk); #1 in_valid_w = 1'b0;
        end
        for (int i = 0; i < 20 && finished_w !== 1'b1; i++) @(negedge clk);
        check("w_finished", finished_w, 1);
        check("w_cycle_count", cycle_count_w, 1);
        check("w_no_out_valid", ov_w_cnt, 0);
        check("w_writes_left", wq2.size(), 0);
        check("w_timed_out", timed_out_w, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
